// File: rtl/rst_seq.sv
// Reset sequencer: holds all channels in reset, then releases them one at a time in index order.
// Define RST_SEQ_ACK_EN to wait for each released channel's acknowledge (with timeout) before the next release.
module rst_seq #(
    parameter int N_CH        = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rst_req,
    output logic [N_CH-1:0] ch_rst,
    output logic            busy,
    output logic            rst_done
`ifdef RST_SEQ_ACK_EN
    ,
    input  logic [N_CH-1:0] ch_ack,
    output logic [N_CH-1:0] ack_err
`endif
);

    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
    localparam int CW      = ($clog2(MAX_ALL + 1) > 1) ? $clog2(MAX_ALL + 1) : 1;
    localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_CH - 1);

    typedef enum logic [2:0] {
        HOLD,
        GAP,
        RELEASE,
`ifdef RST_SEQ_ACK_EN
        WAIT_ACK,
`endif
        IDLE
    } state_t;

    // Where to go after a channel is released that is not the last one
`ifdef RST_SEQ_ACK_EN
    localparam state_t AFTER_REL = WAIT_ACK;
`else
    localparam state_t AFTER_REL = (GAP_CYCLES == 0) ? RELEASE : GAP;
`endif
    localparam state_t TO_GAP = (GAP_CYCLES == 0) ? RELEASE : GAP;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [N_CH-1:0] ch_rst_reg, ch_rst_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    // Set by rst_n so the first edge after release behaves like a sampled rst_req
    logic            start_reg;
`ifdef RST_SEQ_ACK_EN
    logic [N_CH-1:0] ack_err_reg, ack_err_next;
    logic [IW-1:0]   ack_idx;
    assign ack_idx = idx_reg - IW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            ch_rst_reg  <= '1;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            start_reg   <= 1'b1;
`ifdef RST_SEQ_ACK_EN
            ack_err_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            ch_rst_reg  <= ch_rst_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            start_reg   <= 1'b0;
`ifdef RST_SEQ_ACK_EN
            ack_err_reg <= ack_err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        ch_rst_next  = ch_rst_reg;
        done_next    = done_reg;
`ifdef RST_SEQ_ACK_EN
        ack_err_next = ack_err_reg;
`endif
        if (rst_req || start_reg) begin
            state_next   = HOLD;
            cnt_next     = '0;
            idx_next     = '0;
            ch_rst_next  = '1;
            done_next    = 1'b0;
`ifdef RST_SEQ_ACK_EN
            ack_err_next = '0;
`endif
        end else begin
            case (state_reg)
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        ch_rst_next[0] = 1'b0;
                        cnt_next       = '0;
                        idx_next       = IW'(1);
                        state_next     = (N_CH == 1) ? IDLE : AFTER_REL;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_next   = '0;
                        state_next = RELEASE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                RELEASE: begin
                    ch_rst_next[idx_reg] = 1'b0;
                    cnt_next             = '0;
                    if (idx_reg == IDX_LAST) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + IW'(1);
                        state_next = AFTER_REL;
                    end
                end
`ifdef RST_SEQ_ACK_EN
                WAIT_ACK: begin
                    if (ch_ack[ack_idx]) begin
                        cnt_next   = '0;
                        state_next = TO_GAP;
                    end else if (cnt_reg == CW'(ACK_TIMEOUT - 1)) begin
                        ack_err_next[ack_idx] = 1'b1;
                        cnt_next              = '0;
                        state_next            = TO_GAP;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
`endif
                IDLE: begin
                    done_next = 1'b1;
                end
                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
        busy_next = !done_next;
    end

    assign ch_rst   = ch_rst_reg;
    assign busy     = busy_reg;
    assign rst_done = done_reg;
`ifdef RST_SEQ_ACK_EN
    assign ack_err  = ack_err_reg;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a 3-channel instance (HOLD=4, GAP=2) and a 4-channel instance (HOLD=1, GAP=0).
module tb_rst_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, rst_req_a, busy_a, done_a;
    logic [2:0] ch_rst_a;
    logic       rst_n_b, rst_req_b, busy_b, done_b;
    logic [3:0] ch_rst_b;

    rst_seq #(.N_CH(3), .HOLD_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .rst_req(rst_req_a),
        .ch_rst(ch_rst_a), .busy(busy_a), .rst_done(done_a)
    );

    rst_seq #(.N_CH(4), .HOLD_CYCLES(1), .GAP_CYCLES(0), .ACK_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .rst_req(rst_req_b),
        .ch_rst(ch_rst_b), .busy(busy_b), .rst_done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       req;
        logic [2:0] ch;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t       tab[23];
    logic [5:0] exp_b[6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [7:0] obs_a();
        return {3'b000, ch_rst_a, busy_a, done_a};
    endfunction

    function automatic logic [7:0] obs_b();
        return {2'b00, ch_rst_b, busy_b, done_b};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // edge k: {rst_req sampled at edge k, ch_rst, busy, rst_done after edge k}
        tab[0]  = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[1]  = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[2]  = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[4]  = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 3'b100, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 3'b100, 1'b1, 1'b0};
        tab[9]  = '{1'b1, 3'b111, 1'b1, 1'b0};
        tab[10] = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[11] = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[12] = '{1'b0, 3'b111, 1'b1, 1'b0};
        tab[13] = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[14] = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[15] = '{1'b0, 3'b110, 1'b1, 1'b0};
        tab[16] = '{1'b0, 3'b100, 1'b1, 1'b0};
        tab[17] = '{1'b0, 3'b100, 1'b1, 1'b0};
        tab[18] = '{1'b0, 3'b100, 1'b1, 1'b0};
        tab[19] = '{1'b0, 3'b000, 1'b1, 1'b0};
        tab[20] = '{1'b0, 3'b000, 1'b0, 1'b1};
        tab[21] = '{1'b0, 3'b000, 1'b0, 1'b1};
        tab[22] = '{1'b0, 3'b000, 1'b0, 1'b1};
        // {ch_rst, busy, rst_done} for the zero-gap instance, edges 0..5
        exp_b[0] = 6'b1111_10;
        exp_b[1] = 6'b1110_10;
        exp_b[2] = 6'b1100_10;
        exp_b[3] = 6'b1000_10;
        exp_b[4] = 6'b0000_10;
        exp_b[5] = 6'b0000_01;

        rst_n_a   = 1'b1;
        rst_n_b   = 1'b1;
        rst_req_a = 1'b0;
        rst_req_b = 1'b0;
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #1;
        check("reset_a", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});
        check("reset_b", obs_b(), {2'b00, 4'b1111, 1'b1, 1'b0});
        step(1);
        check("reset_a_held", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});

        // Power-up sequence followed by a rst_req restart mid-sequence
        rst_n_a = 1'b1;
        for (int k = 0; k < 23; k++) begin
            rst_req_a = tab[k].req;
            step(1);
            check($sformatf("seq_a_edge%0d", k), obs_a(),
                  {3'b000, tab[k].ch, tab[k].busy, tab[k].done});
        end
        rst_req_a = 1'b0;

        // rst_req while idle
        rst_req_a = 1'b1;
        step(1);
        check("idle_req", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});
        rst_req_a = 1'b0;
        step(4);
        check("idle_req_rel0", obs_a(), {3'b000, 3'b110, 1'b1, 1'b0});
        step(1);
        check("in_gap", obs_a(), {3'b000, 3'b110, 1'b1, 1'b0});

        // Asynchronous reset in the middle of a gap, no clock edge in between
        rst_n_a = 1'b0;
        #1;
        check("async_mid_gap", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});
        step(1);
        check("async_held", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});
        rst_n_a = 1'b1;
        step(4);
        check("rerun_edge3", obs_a(), {3'b000, 3'b111, 1'b1, 1'b0});
        step(1);
        check("rerun_edge4", obs_a(), {3'b000, 3'b110, 1'b1, 1'b0});

        // Zero-gap instance: channels clear on consecutive edges
        rst_n_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            check($sformatf("seq_b_edge%0d", k), obs_b(), {2'b00, exp_b[k]});
        end
        step(3);
        check("seq_b_stays_done", obs_b(), {2'b00, 4'b0000, 1'b0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of reset channels (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles all channels are held in reset before the first release (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between consecutive channel releases (>=0).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024, maximum wait cycles for a channel acknowledge (>=1; used only under RST_SEQ_ACK_EN).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rst_req, input, 1, synchronous active-high request to re-run the reset sequence.
REQ-008 SHALL have port ch_rst, output, N_CH, active-high per-channel resets; bit 0 releases first.
REQ-009 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-010 SHALL have port rst_done, output, 1, high when all channels are released and the block is idle.
REQ-011 SHALL have port ch_ack, input, N_CH, per-channel ready acknowledge (present only under RST_SEQ_ACK_EN).
REQ-012 SHALL have port ack_err, output, N_CH, sticky per-channel acknowledge-timeout flags (present only under RST_SEQ_ACK_EN).

Function
REQ-013 SHALL implement FSM states HOLD, GAP, RELEASE, WAIT_ACK (macro only) and IDLE; all outputs SHALL be registered.
REQ-014 HOLD: counter runs 0..HOLD_CYCLES-1, ch_rst all ones; on the last count SHALL clear ch_rst[0] and go to GAP, or to IDLE if N_CH==1.
REQ-015 GAP: counter runs GAP_CYCLES cycles; with GAP_CYCLES==0 it SHALL be skipped; on exit the block SHALL go to RELEASE.
REQ-016 RELEASE: SHALL clear ch_rst[idx] for the next channel index, increment idx, and go to GAP, or to IDLE after channel N_CH-1.
REQ-017 Timing (no macro): with rst_req sampled at edge T, ch_rst SHALL be all ones after T; ch_rst[0] SHALL clear at edge T+HOLD_CYCLES; ch_rst[i] SHALL clear at T+HOLD_CYCLES+i*(GAP_CYCLES+1).
REQ-018 rst_done SHALL rise one cycle after the last channel clears; busy SHALL equal the inverse of rst_done.
REQ-019 In IDLE, rst_req high SHALL set ch_rst to all ones, clear rst_done, zero the counter and idx, and enter HOLD.
REQ-020 rst_req high in any non-IDLE state SHALL restart the sequence exactly as REQ-019, re-asserting any channels already released, in the same cycle.
REQ-021 Once a channel is released, ch_rst SHALL never re-assert except through rst_req or rst_n.
REQ-022 Counters SHALL be max($clog2(max(HOLD_CYCLES,GAP_CYCLES,ACK_TIMEOUT)+1),1) bits wide and SHALL never wrap.

Reset
REQ-023 rst_n low SHALL immediately set ch_rst to all ones, busy=1, rst_done=0, ack_err=0, counter=0 and idx=0, and SHALL put the FSM in HOLD.
REQ-024 After rst_n deasserts, the sequence SHALL start automatically from HOLD at the first clock edge, as if rst_req had been sampled at that edge.
REQ-025 Assertion of rst_n mid-sequence SHALL abort the sequence with no partial release.

Configuration
REQ-026 Macro RST_SEQ_ACK_EN: when defined, after releasing channel i<N_CH-1 the FSM SHALL enter WAIT_ACK and hold until ch_ack[i]==1, then enter GAP.
REQ-027 With RST_SEQ_ACK_EN, if ch_ack[i] stays low for ACK_TIMEOUT cycles, ack_err[i] SHALL set (sticky until rst_n or rst_req) and the sequence SHALL proceed to GAP.
REQ-028 Without RST_SEQ_ACK_EN, ch_ack, ack_err and WAIT_ACK SHALL not exist, and timing SHALL be exactly REQ-017.

Verification
REQ-029 N_CH=3, HOLD=4, GAP=2, no macro; release rst_n -> ch_rst 111, then ch_rst[0] clears at cycle 4, [1] at 7, [2] at 10, rst_done=1 at 11.
REQ-030 Same configuration, pulse rst_req at cycle 8 (ch_rst=100) -> ch_rst=111 at cycle 9, then the full sequence re-runs with the same offsets.
REQ-031 GAP=0, N_CH=4, HOLD=1 -> channels clear on 4 consecutive cycles; rst_done follows one cycle later.
REQ-032 Assert rst_n low mid-GAP -> ch_rst=all ones and busy=1 in the same cycle, with no clock edge needed.
REQ-033 With RST_SEQ_ACK_EN, N_CH=2, ACK_TIMEOUT=8, ch_ack tied 0 -> ack_err[0]=1 after 8 wait cycles, ch_rst[1] clears GAP+1 cycles later, and the next rst_req clears ack_err.
REQ-034 With RST_SEQ_ACK_EN, ch_ack[0] rising 3 cycles after release -> ch_rst[1] clears 3+GAP+1 cycles after ch_rst[0] clears, with ack_err=0.
